// File: rtl/kbd_event_fifo.sv
// kbd_event_fifo
//   Buffers keyboard events from the PS/2 decode stage until software polls
//   them over a small MMIO window. Each event is a {release flag, ASCII} word.
//
// Ports
//   clk        system clock
//   rst        synchronous, active-high reset
//   key_valid  one-cycle pulse from the decoder: key_data is valid
//   key_data   [15:9] zero, [8] release flag, [7:0] ASCII
//   key_ack    registered pulse, the cycle after an event is enqueued
//   cpu_ren    one-cycle MMIO read strobe
//   cpu_addr   0 = DATA (pops one entry), 1 = STATUS (clears overflow/drops)
//   cpu_rdata  registered read data, updated one cycle after cpu_ren
//   irq        level interrupt, high while the FIFO holds at least one entry
//
// Handshake: the decoder offers an event with a one-cycle key_valid pulse and
// keeps it in its holding register until key_ack comes back. key_ack is only
// raised for events that were actually stored; dropped (FIFO full) and
// filtered (release with KEEP_RELEASE = 0) events are never acknowledged.
// The CPU side has no back-pressure: every cpu_ren is answered one cycle
// later on cpu_rdata, which then holds until the next cpu_ren.
//
// STATUS word: {drop_cnt[7:0], count[6:0] (saturated at 127), overflow}.

module kbd_event_fifo #(
  parameter int DEPTH        = 16,
  parameter bit KEEP_RELEASE = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        key_valid,
  input  logic [15:0] key_data,
  output logic        key_ack,
  input  logic        cpu_ren,
  input  logic        cpu_addr,
  output logic [15:0] cpu_rdata,
  output logic        irq
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [15:0]   mem [DEPTH];
  logic [AW-1:0] head;
  logic [AW-1:0] tail;
  logic [CW-1:0] count;
  logic [CW-1:0] count_next;
  logic          overflow;
  logic [7:0]    drop_cnt;

  logic          push_req;
  logic          data_rd;
  logic          stat_rd;
  logic          empty;
  logic          full;
  logic          pop;
  logic          push;
  logic          drop;
  logic [8:0]    count_ext;
  logic [6:0]    count_sat;
  logic [15:0]   status_word;

  // Release events are filtered before they can influence full/drop logic,
  // so a discarded release never counts as an overflow.
  assign push_req = key_valid && (KEEP_RELEASE || !key_data[8]);
  assign data_rd  = cpu_ren && !cpu_addr;
  assign stat_rd  = cpu_ren && cpu_addr;

  assign empty = (count == '0);
  assign full  = (count == CW'(DEPTH));

  // A pop in the same cycle frees a slot, so a push into a full FIFO is
  // still accepted when it coincides with a DATA read.
  assign pop  = data_rd && !empty;
  assign push = push_req && (!full || pop);
  assign drop = push_req && full && !pop;

  // count is at most 256, so a 9-bit view covers every legal DEPTH.
  assign count_ext   = 9'(count);
  assign count_sat   = (count_ext > 9'd127) ? 7'h7f : count_ext[6:0];
  assign status_word = {drop_cnt, count_sat, overflow};

  always_comb begin
    count_next = count;
    case ({push, pop})
      2'b10:   count_next = count + 1'b1;
      2'b01:   count_next = count - 1'b1;
      default: count_next = count;
    endcase
  end

  // Storage has no reset; only entries between head and tail are ever read.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[tail] <= key_data;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push) begin
        tail <= tail + 1'b1;
      end
      if (pop) begin
        head <= head + 1'b1;
      end
      count <= count_next;
    end
  end

  // A drop in the same cycle as a STATUS read wins over the clear, so the
  // event is never lost from the software's view.
  always_ff @(posedge clk) begin
    if (rst) begin
      overflow <= 1'b0;
      drop_cnt <= 8'h00;
    end else if (drop) begin
      overflow <= 1'b1;
      if (stat_rd) begin
        drop_cnt <= 8'h01;
      end else if (drop_cnt != 8'hff) begin
        drop_cnt <= drop_cnt + 8'h01;
      end
    end else if (stat_rd) begin
      overflow <= 1'b0;
      drop_cnt <= 8'h00;
    end
  end

  // Read data: an empty DATA read returns 0, which software treats as
  // "no key" (ASCII 0x00 is never produced by the decoder).
  always_ff @(posedge clk) begin
    if (rst) begin
      cpu_rdata <= 16'h0000;
    end else if (data_rd) begin
      cpu_rdata <= pop ? mem[head] : 16'h0000;
    end else if (stat_rd) begin
      cpu_rdata <= status_word;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      key_ack <= 1'b0;
      irq     <= 1'b0;
    end else begin
      key_ack <= push;
      irq     <= (count_next != '0);
    end
  end

endmodule

// File: tb/tb_kbd_event_fifo.sv
// Bench for kbd_event_fifo. Two instances share one stimulus stream:
//   inst0: DEPTH = 4,  KEEP_RELEASE = 1
//   inst1: DEPTH = 16, KEEP_RELEASE = 0
// A queue-based reference model predicts rdata/ack/irq for both every cycle.

module tb_kbd_event_fifo;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        key_valid = 1'b0;
  logic [15:0] key_data = 16'h0000;
  logic        cpu_ren = 1'b0;
  logic        cpu_addr = 1'b0;

  logic        ack_a, ack_b, irq_a, irq_b;
  logic [15:0] rdata_a, rdata_b;

  logic [15:0] rdata_w [2];
  logic        ack_w [2];
  logic        irq_w [2];

  assign rdata_w[0] = rdata_a;
  assign rdata_w[1] = rdata_b;
  assign ack_w[0]   = ack_a;
  assign ack_w[1]   = ack_b;
  assign irq_w[0]   = irq_a;
  assign irq_w[1]   = irq_b;

  int checks = 0;
  int errors = 0;

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- DUTs ----------------
  kbd_event_fifo #(.DEPTH(4), .KEEP_RELEASE(1'b1)) u_dut_a (
    .clk(clk), .rst(rst), .key_valid(key_valid), .key_data(key_data),
    .key_ack(ack_a), .cpu_ren(cpu_ren), .cpu_addr(cpu_addr),
    .cpu_rdata(rdata_a), .irq(irq_a)
  );

  kbd_event_fifo #(.DEPTH(16), .KEEP_RELEASE(1'b0)) u_dut_b (
    .clk(clk), .rst(rst), .key_valid(key_valid), .key_data(key_data),
    .key_ack(ack_b), .cpu_ren(cpu_ren), .cpu_addr(cpu_addr),
    .cpu_rdata(rdata_b), .irq(irq_b)
  );

  // ---------------- reference model ----------------
  logic [15:0] exp_q_a [$];
  logic [15:0] exp_q_b [$];
  logic [15:0] exp_rdata [2];
  logic        exp_ack [2];
  logic        exp_irq [2];
  logic        exp_ovf [2];
  int          exp_drop [2];

  function automatic int q_size(input int i);
    return (i == 0) ? exp_q_a.size() : exp_q_b.size();
  endfunction

  function automatic logic [15:0] q_front(input int i);
    return (i == 0) ? exp_q_a[0] : exp_q_b[0];
  endfunction

  task automatic q_pop(input int i);
    if (i == 0) void'(exp_q_a.pop_front());
    else        void'(exp_q_b.pop_front());
  endtask

  task automatic q_push(input int i, input logic [15:0] v);
    if (i == 0) exp_q_a.push_back(v);
    else        exp_q_b.push_back(v);
  endtask

  task automatic q_clear(input int i);
    if (i == 0) exp_q_a.delete();
    else        exp_q_b.delete();
  endtask

  // Predicts the state after the coming edge from the inputs now applied.
  task automatic model_step();
    for (int i = 0; i < 2; i++) begin
      int          depth;
      bit          keep;
      int          n;
      bit          push_req, pop, dropped;
      logic [7:0]  d8;
      logic [6:0]  c7;
      depth = (i == 0) ? 4 : 16;
      keep  = (i == 0);
      if (rst) begin
        q_clear(i);
        exp_ovf[i] = 1'b0;
        exp_drop[i] = 0;
        exp_rdata[i] = 16'h0000;
        exp_ack[i] = 1'b0;
        exp_irq[i] = 1'b0;
        continue;
      end
      n        = q_size(i);
      push_req = key_valid && (keep || !key_data[8]);
      pop      = cpu_ren && !cpu_addr && (n > 0);
      dropped  = push_req && (n == depth) && !pop;
      if (cpu_ren) begin
        if (cpu_addr) begin
          d8 = 8'(exp_drop[i]);
          c7 = 7'((n > 127) ? 127 : n);
          exp_rdata[i] = {d8, c7, exp_ovf[i]};
        end else begin
          exp_rdata[i] = (n > 0) ? q_front(i) : 16'h0000;
        end
      end
      if (pop) q_pop(i);
      if (push_req && !dropped) q_push(i, key_data);
      exp_ack[i] = push_req && !dropped;
      if (cpu_ren && cpu_addr) begin
        exp_ovf[i] = 1'b0;
        exp_drop[i] = 0;
      end
      if (dropped) begin
        exp_ovf[i] = 1'b1;
        exp_drop[i] = (exp_drop[i] < 255) ? exp_drop[i] + 1 : 255;
      end
      exp_irq[i] = (q_size(i) != 0);
    end
  endtask

  // ---------------- driver ----------------
  task automatic tick(input logic kv, input logic [15:0] kd,
                      input logic ren, input logic addr);
    key_valid = kv;
    key_data  = kd;
    cpu_ren   = ren;
    cpu_addr  = addr;
    model_step();
    @(posedge clk);
    #1;
    key_valid = 1'b0;
    key_data  = 16'h0000;
    cpu_ren   = 1'b0;
    cpu_addr  = 1'b0;
  endtask

  function automatic logic [15:0] rand_key();
    logic [15:0] k;
    k = 16'h0000;
    k[8] = 1'($urandom_range(0, 1));
    k[7:0] = 8'($urandom_range(1, 255));
    return k;
  endfunction

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1;
    tick(1'b0, 16'h0, 1'b0, 1'b0);
    tick(1'b0, 16'h0, 1'b0, 1'b0);
    rst = 1'b0;
    for (int i = 0; i < 2; i++) begin
      checks++;
      if ({ack_w[i], irq_w[i], rdata_w[i]} !== {1'b0, 1'b0, 16'h0000}) begin
        errors++;
        $display("FAIL reset inst%0d: ack/irq/rdata got %b/%b/%h want 0/0/0000",
                 i, ack_w[i], irq_w[i], rdata_w[i]);
      end
    end
  endtask

  task automatic test_basic();
    logic [15:0] kd [7]  = '{16'h0041, 16'h0142, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0};
    logic        kv [7]  = '{1, 1, 0, 0, 0, 0, 0};
    logic        ren [7] = '{0, 0, 0, 1, 1, 1, 0};
    logic [15:0] lit_a [7] = '{16'h0, 16'h0, 16'h0, 16'h0041, 16'h0142, 16'h0000, 16'h0000};
    for (int s = 0; s < 7; s++) begin
      tick(kv[s], kd[s], ren[s], 1'b0);
      for (int i = 0; i < 2; i++) begin
        checks++;
        if ({ack_w[i], irq_w[i], rdata_w[i]} !== {exp_ack[i], exp_irq[i], exp_rdata[i]}) begin
          errors++;
          $display("FAIL basic step%0d inst%0d: ack/irq/rdata got %b/%b/%h want %b/%b/%h",
                   s, i, ack_w[i], irq_w[i], rdata_w[i], exp_ack[i], exp_irq[i], exp_rdata[i]);
        end
      end
      checks++;
      if (rdata_a !== lit_a[s]) begin
        errors++;
        $display("FAIL basic_literal step%0d: rdata got %h want %h", s, rdata_a, lit_a[s]);
      end
    end
  endtask

  task automatic test_overflow();
    for (int s = 0; s < 6; s++) begin
      tick(1'b1, 16'h0061 + 16'(s), 1'b0, 1'b0);
      checks++;
      if (ack_a !== (s < 4)) begin
        errors++;
        $display("FAIL overflow_ack push%0d: ack got %b want %b", s, ack_a, (s < 4));
      end
    end
    tick(1'b0, 16'h0, 1'b1, 1'b1);
    checks++;
    if (rdata_a !== 16'h0209) begin
      errors++;
      $display("FAIL overflow_status1: got %h want 0209", rdata_a);
    end
    tick(1'b0, 16'h0, 1'b1, 1'b1);
    checks++;
    if (rdata_a !== 16'h0008) begin
      errors++;
      $display("FAIL overflow_status2: got %h want 0008", rdata_a);
    end
    for (int s = 0; s < 8; s++) begin
      tick(1'b0, 16'h0, 1'b1, 1'b0);
      if (s < 4) begin
        checks++;
        if (rdata_a !== 16'h0061 + 16'(s)) begin
          errors++;
          $display("FAIL overflow_drain%0d: got %h want %h", s, rdata_a, 16'h0061 + 16'(s));
        end
      end
      for (int i = 0; i < 2; i++) begin
        checks++;
        if ({ack_w[i], irq_w[i], rdata_w[i]} !== {exp_ack[i], exp_irq[i], exp_rdata[i]}) begin
          errors++;
          $display("FAIL overflow_model step%0d inst%0d: got %b/%b/%h want %b/%b/%h",
                   s, i, ack_w[i], irq_w[i], rdata_w[i], exp_ack[i], exp_irq[i], exp_rdata[i]);
        end
      end
    end
  endtask

  task automatic test_full_push_pop();
    for (int s = 0; s < 4; s++) tick(1'b1, 16'h0031 + 16'(s), 1'b0, 1'b0);
    tick(1'b1, 16'h0070, 1'b1, 1'b0);
    checks++;
    if ({ack_a, rdata_a} !== {1'b1, 16'h0031}) begin
      errors++;
      $display("FAIL full_pushpop: ack/rdata got %b/%h want 1/0031", ack_a, rdata_a);
    end
    tick(1'b0, 16'h0, 1'b1, 1'b1);
    checks++;
    if (rdata_a !== 16'h0008) begin
      errors++;
      $display("FAIL full_pushpop_status: got %h want 0008", rdata_a);
    end
    for (int s = 0; s < 6; s++) begin
      tick(1'b0, 16'h0, 1'b1, 1'b0);
      for (int i = 0; i < 2; i++) begin
        checks++;
        if ({ack_w[i], irq_w[i], rdata_w[i]} !== {exp_ack[i], exp_irq[i], exp_rdata[i]}) begin
          errors++;
          $display("FAIL full_drain step%0d inst%0d: got %b/%b/%h want %b/%b/%h",
                   s, i, ack_w[i], irq_w[i], rdata_w[i], exp_ack[i], exp_irq[i], exp_rdata[i]);
        end
      end
    end
  endtask

  task automatic test_wrap();
    for (int s = 0; s < 48; s++) begin
      logic [15:0] k;
      k = {7'b0, 1'b0, 8'(8'h20 + s)};
      tick(1'b1, k, 1'b0, 1'b0);
      tick(1'b0, 16'h0, 1'b1, 1'b0);
      for (int i = 0; i < 2; i++) begin
        checks++;
        if ({irq_w[i], rdata_w[i]} !== {exp_irq[i], exp_rdata[i]}) begin
          errors++;
          $display("FAIL wrap step%0d inst%0d: irq/rdata got %b/%h want %b/%h",
                   s, i, irq_w[i], rdata_w[i], exp_irq[i], exp_rdata[i]);
        end
      end
    end
  endtask

  task automatic test_random();
    for (int s = 0; s < 400; s++) begin
      tick(1'($urandom_range(0, 1)), rand_key(),
           1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 3) == 0));
      for (int i = 0; i < 2; i++) begin
        checks++;
        if ({ack_w[i], irq_w[i], rdata_w[i]} !== {exp_ack[i], exp_irq[i], exp_rdata[i]}) begin
          errors++;
          $display("FAIL random step%0d inst%0d: got %b/%b/%h want %b/%b/%h",
                   s, i, ack_w[i], irq_w[i], rdata_w[i], exp_ack[i], exp_irq[i], exp_rdata[i]);
        end
      end
    end
    for (int s = 0; s < 20; s++) tick(1'b0, 16'h0, 1'b1, 1'b0);
    tick(1'b0, 16'h0, 1'b1, 1'b1);
  endtask

  task automatic test_filter();
    int acks_b;
    acks_b = 0;
    tick(1'b1, 16'h0141, 1'b0, 1'b0);
    acks_b += int'(ack_b);
    tick(1'b1, 16'h0041, 1'b0, 1'b0);
    acks_b += int'(ack_b);
    checks++;
    if (acks_b !== 1) begin
      errors++;
      $display("FAIL filter_acks: got %0d want 1", acks_b);
    end
    tick(1'b0, 16'h0, 1'b1, 1'b1);
    checks++;
    if (rdata_b !== 16'h0002) begin
      errors++;
      $display("FAIL filter_status: got %h want 0002", rdata_b);
    end
    tick(1'b0, 16'h0, 1'b1, 1'b0);
    checks++;
    if ({rdata_a, rdata_b} !== {16'h0141, 16'h0041}) begin
      errors++;
      $display("FAIL filter_data: got %h/%h want 0141/0041", rdata_a, rdata_b);
    end
    tick(1'b0, 16'h0, 1'b1, 1'b0);
    checks++;
    if (rdata_b !== 16'h0000) begin
      errors++;
      $display("FAIL filter_empty: got %h want 0000", rdata_b);
    end
  endtask

  task automatic test_reset_mid();
    for (int s = 0; s < 3; s++) tick(1'b1, 16'h0051 + 16'(s), 1'b0, 1'b0);
    rst = 1'b1;
    tick(1'b0, 16'h0, 1'b1, 1'b0);
    rst = 1'b0;
    for (int i = 0; i < 2; i++) begin
      checks++;
      if ({irq_w[i], rdata_w[i]} !== {1'b0, 16'h0000}) begin
        errors++;
        $display("FAIL reset_mid inst%0d: irq/rdata got %b/%h want 0/0000",
                 i, irq_w[i], rdata_w[i]);
      end
    end
    tick(1'b0, 16'h0, 1'b1, 1'b1);
    checks++;
    if ({rdata_a, rdata_b} !== 32'h0) begin
      errors++;
      $display("FAIL reset_mid_status: got %h/%h want 0000/0000", rdata_a, rdata_b);
    end
    tick(1'b0, 16'h0, 1'b1, 1'b0);
    checks++;
    if ({rdata_a, rdata_b, irq_a, irq_b} !== 34'h0) begin
      errors++;
      $display("FAIL reset_mid_data: got %h/%h irq %b/%b want 0", rdata_a, rdata_b, irq_a, irq_b);
    end
  endtask

  initial begin
    @(posedge clk);
    #1;
    test_reset();
    test_basic();
    test_overflow();
    test_full_push_pop();
    test_wrap();
    test_random();
    test_filter();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
